// File: rtl/pdm_mic_capture.sv
// PDM microphone capture: samples 1-bit PDM data on bclk rising edges,
// counts ones over DECIM bits and emits one signed PCM word per window
// on a valid/ready interface with a sticky overflow flag.
module pdm_mic_capture #(
  parameter int unsigned DECIM = 64,
  parameter int unsigned OUT_W = 16,
  localparam int unsigned CNT_W = $clog2(DECIM) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bclk,
  input  logic             mic_data,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CAPTURE = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DECIM - 1);
  localparam logic [OUT_W-1:0] MID      = OUT_W'(DECIM / 2);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] ones_nxt;
  logic [CNT_W-1:0] ones_sum_c;
  logic [OUT_W-1:0] sample_c;
  logic             bclk_q;
  logic             mic_s1;
  logic             mic_s;
  logic             rise_c;
  logic             complete_c;

  assign rise_c     = bclk & ~bclk_q;
  assign ones_sum_c = ones_cnt + CNT_W'(mic_s);
  // Zero-extend the ones count, then subtract mid-scale: wraps to a signed result.
  assign sample_c   = OUT_W'(ones_sum_c) - MID;

  // Synchronize the asynchronous mic pin and delay bclk for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      mic_s1 <= 1'b0;
      mic_s  <= 1'b0;
      bclk_q <= 1'b1;
    end else begin
      mic_s1 <= mic_data;
      mic_s  <= mic_s1;
      bclk_q <= bclk;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ones_cnt <= ones_nxt;
    end
  end

  // Next-state and counter update; flags the rise that completes a frame.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    ones_nxt    = ones_cnt;
    complete_c  = 1'b0;
    if (!en) begin
      state_nxt   = S_IDLE;
      bit_cnt_nxt = '0;
      ones_nxt    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          bit_cnt_nxt = '0;
          ones_nxt    = '0;
          if (rise_c) begin
            state_nxt   = S_CAPTURE;
            bit_cnt_nxt = CNT_W'(1);
            ones_nxt    = CNT_W'(mic_s);
          end
        end
        S_CAPTURE: begin
          if (rise_c) begin
            if (bit_cnt == LAST_BIT) begin
              complete_c  = 1'b1;
              bit_cnt_nxt = '0;
              ones_nxt    = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
              ones_nxt    = ones_sum_c;
            end
          end
        end
        default: begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
          ones_nxt    = '0;
        end
      endcase
    end
  end

  // Output sample register, valid/ready handshake and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (complete_c) begin
        if (!pcm_valid || pcm_ready) begin
          pcm_data  <= sample_c;
          pcm_valid <= 1'b1;
        end
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
      // A new drop takes priority over a clear in the same cycle.
      if (complete_c && pcm_valid && !pcm_ready) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture with a frame-level reference model.
// bclk runs at 10 clk per period here to keep the run short; the DUT is
// agnostic to the divider ratio.
module tb_pdm_mic_capture;

  localparam int DECIM  = 64;
  localparam int OUT_W  = 16;
  localparam int HALF_P = 5;
  localparam int PERIOD = 2 * HALF_P;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             bclk = 1'b0;
  logic             mic_data;
  logic [OUT_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;
  logic             overflow;
  logic             clr_ovf = 1'b0;

  logic ready_base  = 1'b0;
  logic ready_snipe = 1'b0;
  logic mic_base    = 1'b0;
  logic mic_tog     = 1'b0;
  logic tog_mode    = 1'b0;
  logic snipe_arm   = 1'b0;
  int   snipe_cnt   = 0;
  int   ph          = 0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  assign mic_data  = tog_mode ? mic_tog : mic_base;
  assign pcm_ready = ready_base | ready_snipe;

  pdm_mic_capture #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bclk      (bclk),
    .mic_data  (mic_data),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: bits collected per frame in a queue, PCM = ones - DECIM/2.
  int         m_q[$];
  logic       m_prev_b = 1'b1;
  logic       m1 = 1'b0;
  logic       m2 = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_ovf = 1'b0;
  logic [15:0] exp_data = '0;

  always @(posedge clk) begin : model
    int   sum;
    logic rise;
    logic done;
    logic xfer;
    logic drop;
    logic [15:0] smp;
    if (reset) begin
      m_q.delete();
      m_prev_b  = 1'b1;
      m1        = 1'b0;
      m2        = 1'b0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_data  = '0;
    end else begin
      rise = bclk && !m_prev_b;
      done = 1'b0;
      drop = 1'b0;
      smp  = '0;
      if (!en) begin
        m_q.delete();
      end else if (rise) begin
        m_q.push_back(int'(m2));
        if (m_q.size() == DECIM) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          smp  = 16'(sum - DECIM / 2);
          done = 1'b1;
          m_q.delete();
        end
      end
      xfer = exp_valid && pcm_ready;
      if (done) begin
        if (!exp_valid || pcm_ready) begin
          exp_data  = smp;
          exp_valid = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (xfer) begin
        exp_valid = 1'b0;
      end
      if (drop) exp_ovf = 1'b1;
      else if (clr_ovf) exp_ovf = 1'b0;
      m_prev_b = bclk;
      m2 = m1;
      m1 = mic_data;
    end
  end

  // bclk generator; optionally toggles mic per period and raises ready
  // exactly for the cycle in which a frame completes.
  always @(negedge clk) begin : driver
    logic nb;
    ph = (ph == PERIOD - 1) ? 0 : ph + 1;
    nb = (ph >= HALF_P);
    ready_snipe = snipe_arm && nb && !bclk && en && !reset && (m_q.size() == DECIM - 1);
    if (ready_snipe) snipe_cnt = snipe_cnt + 1;
    if (!nb && bclk) mic_tog = ~mic_tog;
    bclk = nb;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Advance one cycle and compare all outputs with the model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check("model_valid", 32'(pcm_valid), 32'(exp_valid));
    check("model_ovf",   32'(overflow),  32'(exp_ovf));
    check("model_data",  32'(pcm_data),  32'(exp_data));
  endtask

  task automatic wait_valid(input int budget, output int t);
    int k = 0;
    while (!pcm_valid && k < budget) begin
      tick();
      k++;
    end
    check("wait_valid_timeout", 32'(pcm_valid), 32'd1);
    t = cyc;
  endtask

  initial begin : stim
    int t1;
    int t2;
    int k;
    reset = 1'b1;
    mic_base = 1'b1;
    ready_base = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(pcm_valid), 32'd0);
    check("rst_data",  32'(pcm_data),  32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    reset = 1'b0;
    repeat (5) tick();

    // All ones -> +32, one sample per DECIM bclk periods.
    en = 1'b1;
    wait_valid(DECIM * PERIOD + 30, t1);
    check("ones_first", 32'(pcm_data), 32'h0020);
    tick();
    wait_valid(DECIM * PERIOD + 30, t2);
    check("ones_second", 32'(pcm_data), 32'h0020);
    check("frame_period", 32'(t2 - t1), 32'(DECIM * PERIOD));
    tick();

    // All zeros -> -32.
    mic_base = 1'b0;
    wait_valid(DECIM * PERIOD + 30, t1);
    check("zeros", 32'(pcm_data), 32'hFFE0);
    tick();

    // Alternating bits -> 0.
    tog_mode = 1'b1;
    wait_valid(DECIM * PERIOD + 30, t1);
    check("toggle", 32'(pcm_data), 32'h0000);
    tick();
    tog_mode = 1'b0;

    // Hold ready low across two completions: first kept, second dropped.
    ready_base = 1'b0;
    mic_base = 1'b1;
    wait_valid(DECIM * PERIOD + 30, t1);
    check("held_first", 32'(pcm_data), 32'h0020);
    tick();
    mic_base = 1'b0;
    k = 0;
    while (!overflow && k < DECIM * PERIOD + 30) begin
      tick();
      k++;
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_data_kept", 32'(pcm_data), 32'h0020);
    check("ovf_valid_kept", 32'(pcm_valid), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tick();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Ready asserted exactly in a completion cycle while a sample is held.
    snipe_arm = 1'b1;
    k = 0;
    while (snipe_cnt == 0 && k < DECIM * PERIOD + 30) begin
      tick();
      k++;
    end
    check("snipe_fired", 32'(snipe_cnt), 32'd1);
    snipe_arm = 1'b0;
    tick();
    check("snipe_data", 32'(pcm_data), 32'hFFE0);
    check("snipe_valid", 32'(pcm_valid), 32'd1);
    check("snipe_ovf", 32'(overflow), 32'd0);
    ready_base = 1'b1;
    tick();
    tick();

    // Partial all-ones frame discarded by en low, then a clean zero frame.
    en = 1'b0;
    repeat (3) tick();
    mic_base = 1'b1;
    en = 1'b1;
    k = 0;
    while (m_q.size() < 30 && k < 40 * PERIOD) begin
      tick();
      k++;
    end
    en = 1'b0;
    repeat (20) tick();
    mic_base = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    wait_valid(DECIM * PERIOD + 30, t1);
    check("en_restart", 32'(pcm_data), 32'hFFE0);
    tick();

    // Reset mid-frame with a pending sample.
    ready_base = 1'b0;
    mic_base = 1'b1;
    wait_valid(DECIM * PERIOD + 30, t1);
    check("pre_rst_sample", 32'(pcm_data), 32'h0020);
    k = 0;
    while (m_q.size() < 10 && k < 20 * PERIOD) begin
      tick();
      k++;
    end
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(pcm_valid), 32'd0);
    check("midrst_data",  32'(pcm_data),  32'd0);
    check("midrst_ovf",   32'(overflow),  32'd0);
    reset = 1'b0;
    t1 = cyc;
    wait_valid(DECIM * PERIOD + 30, t2);
    check("post_rst_sample", 32'(pcm_data), 32'h0020);
    check("post_rst_full_frame",
          32'((t2 - t1) >= (DECIM - 1) * PERIOD + 1 && (t2 - t1) <= DECIM * PERIOD + 2), 32'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
